// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift register sequencer: state encoding and counter sizing.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    GAP     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Bit counter must be able to represent the full word width.
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_register_ctrl_gap_timer.sv
// Loadable down-counter that times the idle cycles between shift pulses.
// Saturates at zero so a full-scale load never wraps.
module gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load takes priority; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/shift_register_ctrl.sv
// Sequencer for one serial-in shift register.
//
//   state   | meaning
//   IDLE    | waiting for a word, in_ready high
//   SHIFT   | one shift pulse presented to the register
//   GAP     | idle cycles between pulses, data held
//   CAPTURE | sample the register after the final shift
//   DONE    | captured word offered on the result port
module shift_register_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic [DIV_W-1:0] div,
  output logic             sr_data,
  output logic             sr_shift_enable,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             busy
);

  localparam int CNT_W = bit_cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               sr_data_q, sr_data_d;
  logic               sr_shift_enable_q, sr_shift_enable_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_word_q, out_word_d;
  logic               gap_load, gap_dec, gap_expire;
  logic               accept;

  // word_q always holds the bits still to be sent with the next one at its head.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  gap_timer #(.W(DIV_W)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (div_q),
    .dec      (gap_dec),
    .expire   (gap_expire)
  );

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= IDLE;
      word_q            <= '0;
      div_q             <= '0;
      bit_cnt_q         <= '0;
      sr_data_q         <= 1'b0;
      sr_shift_enable_q <= 1'b0;
      out_valid_q       <= 1'b0;
      out_word_q        <= '0;
    end else begin
      state_q           <= state_d;
      word_q            <= word_d;
      div_q             <= div_d;
      bit_cnt_q         <= bit_cnt_d;
      sr_data_q         <= sr_data_d;
      sr_shift_enable_q <= sr_shift_enable_d;
      out_valid_q       <= out_valid_d;
      out_word_q        <= out_word_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT: begin
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = CAPTURE;
        else if (div_q == '0)               state_d = SHIFT;
        else                                state_d = GAP;
      end
      GAP:     if (gap_expire) state_d = SHIFT;
      CAPTURE: state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    word_d            = word_q;
    div_d             = div_q;
    bit_cnt_d         = bit_cnt_q;
    sr_data_d         = sr_data_q;
    out_word_d        = out_word_q;
    sr_shift_enable_d = (state_d == SHIFT);
    out_valid_d       = (state_d == DONE);
    gap_load          = (state_q == SHIFT) && (state_d == GAP);
    gap_dec           = (state_q == GAP);

    if (accept) begin
      div_d     = div;
      bit_cnt_d = '0;
      sr_data_d = head_bit(in_word);
      word_d    = drop_head(in_word);
    end else if (state_d == SHIFT) begin
      sr_data_d = head_bit(word_q);
      word_d    = drop_head(word_q);
    end

    if (state_q == SHIFT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    if (state_q == CAPTURE) out_word_d = sr_q;
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready = reset && (state_q == IDLE);
    accept   = in_valid && in_ready;
    busy     = (state_q != IDLE);
  end

  assign sr_data         = sr_data_q;
  assign sr_shift_enable = sr_shift_enable_q;
  assign out_valid       = out_valid_q;
  assign out_word        = out_word_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Bench for shift_register_ctrl driving a behavioural 8-bit shift register.
module tb_shift_register_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_word = '0;
  logic [7:0] div = '0;
  logic [7:0] sr_q = '0;
  logic       in_ready, sr_data, sr_shift_enable, out_valid, busy;
  logic [7:0] out_word;

  int errors = 0;
  int checks = 0;
  int pulse_total = 0;

  shift_register_ctrl #(.WIDTH(8), .DIV_W(8), .MSB_FIRST(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_word         (in_word),
    .div             (div),
    .sr_data         (sr_data),
    .sr_shift_enable (sr_shift_enable),
    .sr_q            (sr_q),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_word        (out_word),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Serial-in register the controller drives.
  always @(posedge clk) begin
    if (sr_shift_enable) begin
      sr_q <= {sr_q[6:0], sr_data};
      pulse_total <= pulse_total + 1;
    end
  end

  typedef struct {
    logic [7:0] word;
    logic [7:0] dv;
    int         hold;
    bit         mutate;
    logic [7:0] exp_word;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the k-th bit sent, the word held after all shifts, and the latency.
  function automatic logic send_bit(input logic [7:0] w, input int k);
    return w[7 - k];
  endfunction

  function automatic logic [7:0] model_capture(input logic [7:0] w);
    logic [7:0] q = '0;
    for (int k = 0; k < 8; k++) q = {q[6:0], send_bit(w, k)};
    return q;
  endfunction

  function automatic int model_latency(input logic [7:0] d);
    // last pulse at 7*(d+1) after the first, one CAPTURE cycle, then DONE
    return 7 * (int'(d) + 1) + 2;
  endfunction

  task automatic run_word(input logic [7:0] w, input logic [7:0] d, input int hold,
                          input bit mutate, input logic [7:0] exp_word, input int exp_lat,
                          input string tag);
    int   t;
    int   ptime[$];
    logic pbit[$];
    bit   got_valid;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_word   = w;
    div       = d;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = mutate;
    got_valid = 1'b0;
    for (int c = 1; c <= 2100; c++) begin
      if (sr_shift_enable) begin
        ptime.push_back(c);
        pbit.push_back(sr_data);
      end
      if (out_valid) begin
        check({tag, " latency"}, 32'(c), 32'(1 + exp_lat));
        got_valid = 1'b1;
        break;
      end
      if (mutate && c == 2) begin
        in_word = ~w;
        div     = 8'd0;
      end
      @(negedge clk);
    end
    if (!got_valid) check({tag, " out_valid timeout"}, 32'd0, 32'd1);
    check({tag, " pulse count"}, 32'(ptime.size()), 32'd8);
    for (int k = 0; k < ptime.size() && k < 8; k++) begin
      check($sformatf("%s pulse%0d time", tag, k), 32'(ptime[k]), 32'(1 + k * (int'(d) + 1)));
      check($sformatf("%s pulse%0d bit", tag, k), 32'(pbit[k]), 32'(send_bit(w, k)));
    end
    check({tag, " out_word"}, 32'(out_word), 32'(exp_word));
    in_valid = (hold > 0);
    in_word  = 8'hEE;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold out_word"}, 32'(out_word), 32'(exp_word));
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " post busy"}, 32'(busy), 32'd0);
    check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[5];
    int         p0;
    int         seen;
    logic [7:0] w;
    logic [7:0] d;

    vecs[0] = '{word: 8'hA5, dv: 8'd0, hold: 0,  mutate: 1'b0, exp_word: 8'hA5, exp_lat: 9};
    vecs[1] = '{word: 8'h3C, dv: 8'd3, hold: 0,  mutate: 1'b1, exp_word: 8'h3C, exp_lat: 30};
    vecs[2] = '{word: 8'h5A, dv: 8'd1, hold: 20, mutate: 1'b0, exp_word: 8'h5A, exp_lat: 16};
    vecs[3] = '{word: 8'h01, dv: 8'd0, hold: 0,  mutate: 1'b0, exp_word: 8'h01, exp_lat: 9};
    vecs[4] = '{word: 8'h80, dv: 8'd0, hold: 0,  mutate: 1'b0, exp_word: 8'h80, exp_lat: 9};

    // Held reset with a word offered: nothing moves.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_word  = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst shift_enable", 32'(sr_shift_enable), 32'd0);
      check("rst sr_data", 32'(sr_data), 32'd0);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_word", 32'(out_word), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);

    // Directed vectors; the last two run back-to-back and must total 16 pulses.
    for (int i = 0; i < 3; i++) begin
      run_word(vecs[i].word, vecs[i].dv, vecs[i].hold, vecs[i].mutate,
               vecs[i].exp_word, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end
    p0 = pulse_total;
    for (int i = 3; i < 5; i++) begin
      run_word(vecs[i].word, vecs[i].dv, vecs[i].hold, vecs[i].mutate,
               vecs[i].exp_word, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end
    check("b2b pulse total", 32'(pulse_total - p0), 32'd16);

    // Reset after the third pulse of 8'hFF aborts the word.
    in_valid = 1'b1;
    in_word  = 8'hFF;
    div      = 8'd0;
    @(negedge clk);
    in_valid = 1'b0;
    seen     = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      if (sr_shift_enable) seen++;
      if (seen < 3) @(negedge clk);
    end
    check("abort saw 3 pulses", 32'(seen), 32'd3);
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort shift_enable", 32'(sr_shift_enable), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    p0    = pulse_total;
    repeat (10) @(negedge clk);
    check("abort no pulses", 32'(pulse_total - p0), 32'd0);
    check("abort idle", 32'(busy), 32'd0);
    run_word(8'h81, 8'd0, 0, 1'b0, 8'h81, 9, "after_abort");

    // Random words and gaps against the reference model, then the largest gap.
    repeat (6) begin
      w = 8'($urandom);
      d = 8'($urandom_range(0, 4));
      run_word(w, d, int'($urandom_range(0, 3)), 1'b0, model_capture(w), model_latency(d), "rand");
    end
    w = 8'($urandom);
    run_word(w, 8'd255, 0, 1'b0, model_capture(w), model_latency(8'd255), "maxdiv");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
